// File: rtl/system_bus_interconnect.sv
// Single-master, N-slave memory-mapped bus interconnect.
// Each access is decoded against per-slave base/mask regions. When regions
// overlap, the lowest slave index wins. The access goes to one slave with a
// req/ack handshake. Unmapped addresses and slaves that do not answer in time
// complete with an error. All master-side outputs are registered.
module system_bus_interconnect #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = {32'h00000000, 32'hFF000000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_MASK = {32'h00000000, 32'hFF000000},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_be,
    output logic                         m_ack,
    output logic                         m_err,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         busy,
    output logic [15:0]                  err_count,
    output logic [NUM_SLAVES-1:0]        s_req,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_be,
    input  logic [NUM_SLAVES-1:0]        s_ack,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);

    // A timeout of 0 disables the counter; keep it one bit wide so it still exists.
    localparam int CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TMO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_LAST_I[CNT_W-1:0];

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        tmo_cnt;
    logic [NUM_SLAVES-1:0]   hit_vec;
    logic                    hit;
    logic                    sel_ack;
    logic [DATA_W-1:0]       sel_rdata;

    // Parallel region decode; scanning from the top down leaves the lowest matching index.
    always_comb begin
        hit_vec = '0;
        hit     = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    // The one-hot s_req selects the honoured ack and the returned read-data slice.
    always_comb begin
        sel_ack   = |(s_ack & s_req);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_req[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM with registered master and slave side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            m_ack     <= 1'b0;
            m_err     <= 1'b0;
            m_rdata   <= '0;
            busy      <= 1'b0;
            err_count <= '0;
            s_req     <= '0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_be      <= '0;
        end else begin
            m_ack <= 1'b0;
            m_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_req) begin
                        s_we    <= m_we;
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_be    <= m_be;
                        busy    <= 1'b1;
                        if (hit) begin
                            s_req   <= hit_vec;
                            tmo_cnt <= '0;
                            state   <= ACCESS;
                        end else begin
                            m_ack   <= 1'b1;
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                            state   <= ERR;
                        end
                    end
                end
                ACCESS: begin
                    // An ack arriving on the expiry cycle still completes normally.
                    if (sel_ack) begin
                        m_rdata <= s_we ? '0 : sel_rdata;
                        m_ack   <= 1'b1;
                        s_req   <= '0;
                        state   <= RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST)) begin
                        m_ack   <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                        s_req   <= '0;
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        state   <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                RESP, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    s_req <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_system_bus_interconnect.sv
// Directed testbench for system_bus_interconnect: a default two-slave instance
// and a three-slave instance without a catch-all region.
module tb_system_bus_interconnect;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   tests = 0;
    int   fails = 0;

    // Instance A: default map (slave 0 display, slave 1 catch-all)
    logic        a_req, a_we, a_ack, a_err, a_busy, a_swe;
    logic [31:0] a_addr, a_wdata, a_rdata, a_saddr, a_swdata;
    logic [3:0]  a_be, a_sbe;
    logic [15:0] a_errcnt;
    logic [1:0]  a_sreq, a_sack;
    logic [63:0] a_srdata;

    // Instance B: three slaves, no catch-all
    logic        b_req, b_we, b_ack, b_err, b_busy, b_swe;
    logic [31:0] b_addr, b_wdata, b_rdata, b_saddr, b_swdata;
    logic [3:0]  b_be, b_sbe;
    logic [15:0] b_errcnt;
    logic [2:0]  b_sreq, b_sack;
    logic [95:0] b_srdata;

    system_bus_interconnect dut_a (
        .clk(clk), .reset(reset),
        .m_req(a_req), .m_we(a_we), .m_addr(a_addr), .m_wdata(a_wdata), .m_be(a_be),
        .m_ack(a_ack), .m_err(a_err), .m_rdata(a_rdata), .busy(a_busy), .err_count(a_errcnt),
        .s_req(a_sreq), .s_we(a_swe), .s_addr(a_saddr), .s_wdata(a_swdata), .s_be(a_sbe),
        .s_ack(a_sack), .s_rdata(a_srdata)
    );

    system_bus_interconnect #(
        .NUM_SLAVES(3),
        .REGION_BASE(96'h10000000_00000000_FF000000),
        .REGION_MASK(96'hF0000000_F0000000_FF000000)
    ) dut_b (
        .clk(clk), .reset(reset),
        .m_req(b_req), .m_we(b_we), .m_addr(b_addr), .m_wdata(b_wdata), .m_be(b_be),
        .m_ack(b_ack), .m_err(b_err), .m_rdata(b_rdata), .busy(b_busy), .err_count(b_errcnt),
        .s_req(b_sreq), .s_we(b_swe), .s_addr(b_saddr), .s_wdata(b_swdata), .s_be(b_sbe),
        .s_ack(b_sack), .s_rdata(b_srdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0; a_sack = 0; a_srdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0; b_sack = 0; b_srdata = 0;
        repeat (3) tick();

        // Reset state
        chk("rst_sreq", a_sreq, 0);
        chk("rst_ack", a_ack, 0);
        chk("rst_err", a_err, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_errcnt", a_errcnt, 0);
        chk("rst_sfields", {a_swe, a_saddr, a_swdata, a_sbe}, 0);
        reset = 1'b0;
        tick();

        // Read 0x00001000, slave 1 acks after 3 cycles
        a_req = 1; a_we = 0; a_addr = 32'h00001000; a_be = 4'hF;
        tick();
        a_req = 0;
        chk("rd_sreq1", a_sreq, 2'b10);
        chk("rd_busy", a_busy, 1);
        chk("rd_saddr", a_saddr, 32'h00001000);
        tick();
        chk("rd_sreq2", a_sreq, 2'b10);
        chk("rd_noack2", a_ack, 0);
        tick();
        chk("rd_sreq3", a_sreq, 2'b10);
        a_sack = 2'b10; a_srdata = {32'hCAFEBABE, 32'h0};
        tick();
        a_sack = 0;
        chk("rd_ack", a_ack, 1);
        chk("rd_err", a_err, 0);
        chk("rd_rdata", a_rdata, 32'hCAFEBABE);
        chk("rd_sreq_drop", a_sreq, 0);
        tick();
        chk("rd_ack_pulse", a_ack, 0);
        chk("rd_rdata_hold", a_rdata, 32'hCAFEBABE);
        chk("rd_idle_busy", a_busy, 0);

        // Write 0xFF000010 (overlaps catch-all, slave 0 wins), slave 0 acks next cycle
        a_req = 1; a_we = 1; a_addr = 32'hFF000010; a_wdata = 32'h12345678; a_be = 4'hF;
        a_srdata = {32'h0, 32'hDEADBEEF};
        tick();
        a_req = 0; a_we = 0;
        chk("wr_sreq", a_sreq, 2'b01);
        chk("wr_swe", a_swe, 1);
        chk("wr_swdata", a_swdata, 32'h12345678);
        chk("wr_sbe", a_sbe, 4'hF);
        a_sack = 2'b01;
        tick();
        a_sack = 0;
        chk("wr_ack", a_ack, 1);
        chk("wr_err", a_err, 0);
        chk("wr_rdata_zero", a_rdata, 0);
        tick();
        chk("wr_ack_pulse", a_ack, 0);

        // Non-selected acks ignored; selected ack on the exact timeout cycle wins
        a_req = 1; a_addr = 32'h00002000;
        for (int k = 1; k <= 15; k++) begin
            tick();
            a_req = 0;
            chk("nonsel_sreq", a_sreq, 2'b10);
            chk("nonsel_noack", a_ack, 0);
            a_sack = 2'b01;
        end
        tick();
        chk("edge_sreq", a_sreq, 2'b10);
        chk("edge_noack", a_ack, 0);
        a_sack = 2'b10; a_srdata = {32'h0BADF00D, 32'h0};
        tick();
        a_sack = 0;
        chk("edge_ack", a_ack, 1);
        chk("edge_err", a_err, 0);
        chk("edge_rdata", a_rdata, 32'h0BADF00D);
        chk("edge_errcnt", a_errcnt, 0);
        tick();

        // Timeout: slave never acks
        a_req = 1; a_addr = 32'h00003000;
        for (int k = 1; k <= 16; k++) begin
            tick();
            a_req = 0;
            chk("tmo_sreq_high", a_sreq, 2'b10);
            chk("tmo_noack", a_ack, 0);
        end
        tick();
        chk("tmo_sreq_low", a_sreq, 0);
        chk("tmo_ack", a_ack, 1);
        chk("tmo_err", a_err, 1);
        chk("tmo_rdata", a_rdata, 0);
        chk("tmo_errcnt", a_errcnt, 1);
        a_sack = 2'b10;
        tick();
        chk("late_ack_none1", a_ack, 0);
        tick();
        a_sack = 0;
        chk("late_ack_none2", a_ack, 0);
        chk("late_sreq", a_sreq, 0);
        chk("late_busy", a_busy, 0);
        chk("late_errcnt", a_errcnt, 1);

        // Back-to-back with m_req held high and an always-acking slave
        a_req = 1; a_addr = 32'h00005000; a_sack = 2'b10; a_srdata = {32'h11112222, 32'h0};
        tick();
        chk("b2b_sreq1", a_sreq, 2'b10);
        tick();
        chk("b2b_ack1", a_ack, 1);
        chk("b2b_rdata", a_rdata, 32'h11112222);
        tick();
        chk("b2b_idle_sreq", a_sreq, 0);
        chk("b2b_idle_busy", a_busy, 0);
        tick();
        a_req = 0;
        chk("b2b_sreq2", a_sreq, 2'b10);
        tick();
        a_sack = 0;
        chk("b2b_ack2", a_ack, 1);
        tick();
        chk("b2b_end", a_ack, 0);

        // Reset in the middle of ACCESS
        a_req = 1; a_addr = 32'h00006000;
        tick();
        a_req = 0;
        chk("mid_sreq", a_sreq, 2'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_sreq_drop", a_sreq, 0);
        chk("mid_busy", a_busy, 0);
        chk("mid_noack", a_ack, 0);
        chk("mid_errcnt", a_errcnt, 0);
        a_sack = 2'b10;
        tick();
        a_sack = 0;
        chk("mid_noack2", a_ack, 0);

        // Instance B: hit on slave 2
        b_req = 1; b_addr = 32'h10000040;
        tick();
        b_req = 0;
        chk("b_hit_sreq", b_sreq, 3'b100);
        b_sack = 3'b100; b_srdata = {32'h55AA1234, 32'h99999999, 32'h77777777};
        tick();
        b_sack = 0;
        chk("b_hit_ack", b_ack, 1);
        chk("b_hit_err", b_err, 0);
        chk("b_hit_rdata", b_rdata, 32'h55AA1234);
        tick();

        // Instance B: unmapped address
        b_req = 1; b_addr = 32'h20000000;
        tick();
        b_req = 0;
        chk("miss_sreq", b_sreq, 0);
        chk("miss_ack", b_ack, 1);
        chk("miss_err", b_err, 1);
        chk("miss_rdata", b_rdata, 0);
        chk("miss_errcnt", b_errcnt, 1);
        tick();
        chk("miss_ack_pulse", b_ack, 0);
        chk("miss_busy", b_busy, 0);

        // Instance B: error counter saturation with m_req held on a miss
        b_req = 1;
        repeat (9) tick();
        chk("sat_errcnt6", b_errcnt, 6);
        chk("sat_ack6", b_ack, 1);
        repeat (131100) tick();
        b_req = 0;
        repeat (3) tick();
        chk("sat_errcnt", b_errcnt, 16'hFFFF);
        b_req = 1;
        tick();
        b_req = 0;
        chk("sat_more_ack", b_err, 1);
        chk("sat_hold", b_errcnt, 16'hFFFF);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
